// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg -- shared types and constants for the interrupt controller.
//
// Contents:
//   state_t         controller FSM states (SCAN, PENDING, FINISH)
//   MCAUSE_INT_BIT  bit of mcause that flags an asynchronous interrupt
//   IDX_W           width of the round-robin line index (covers 32 lines)
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        PENDING = 2'd1,
        FINISH  = 2'd2
    } state_t;

    localparam int MCAUSE_INT_BIT = 31;
    localparam int IDX_W          = 5;

endpackage : irq_ctrl_pkg

// File: rtl/irq_ctrl.sv
// irq_ctrl -- CPU-side end of the peripheral int_req/int_fin handshake.
//
// Scans the masked request lines round-robin, raises a single interrupt
// to the core with an mcause value, and when the handler returns (mret)
// emits a one-cycle one-hot completion pulse to the serviced peripheral.
//
// Parameters:
//   N_IRQ       number of implemented request lines (1..32)
//   CAUSE_BASE  cause code reported for line 0; line k reports CAUSE_BASE+k
//
// Ports:
//   clk_i      in   1   clock, rising edge
//   rst_i      in   1   synchronous active-low reset
//   mie_i      in  32   per-line interrupt enable
//   int_req_i  in  32   level requests from peripherals
//   int_fin_o  out 32   one-hot, one-cycle completion pulse
//   int_rst_i  in   1   handler-return strobe (mret executed)
//   irq_o      out  1   interrupt request level to the core
//   mcause_o   out 32   cause of the pending interrupt
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_IRQ      = 32,
    parameter int CAUSE_BASE = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] int_req_i,
    output logic [31:0] int_fin_o,
    input  logic        int_rst_i,
    output logic        irq_o,
    output logic [31:0] mcause_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IRQ - 1);

    state_t           state_reg,  state_next;
    logic [IDX_W-1:0] idx_reg,    idx_next;
    logic             irq_reg,    irq_next;
    logic [31:0]      mcause_reg, mcause_next;
    logic [31:0]      fin_reg,    fin_next;

    logic [31:0]      line_valid;  // 1 for implemented lines
    logic [31:0]      line_sel;    // one-hot decode of idx_reg
    logic [IDX_W-1:0] idx_inc;
    logic             hit;
    logic [31:0]      cause_value;

    // Per-line decode. Lines at or above N_IRQ are tied off so they can
    // never hit and never receive a fin pulse.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_line
            if (gi < N_IRQ) begin : g_impl
                assign line_valid[gi] = 1'b1;
                assign line_sel[gi]   = (idx_reg == IDX_W'(gi));
            end else begin : g_unimpl
                assign line_valid[gi] = 1'b0;
                assign line_sel[gi]   = 1'b0;
            end
        end
    endgenerate

    assign hit     = int_req_i[idx_reg] & mie_i[idx_reg] & line_valid[idx_reg];
    assign idx_inc = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);

    always_comb begin
        cause_value                 = 32'(CAUSE_BASE) + 32'(idx_reg);
        cause_value[MCAUSE_INT_BIT] = 1'b1;
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        irq_next    = irq_reg;
        mcause_next = mcause_reg;
        fin_next    = '0;

        unique case (state_reg)
            SCAN: begin
                if (hit) begin
                    // idx is held so FINISH can pulse the same line.
                    state_next  = PENDING;
                    irq_next    = 1'b1;
                    mcause_next = cause_value;
                end else begin
                    idx_next = idx_inc;
                end
            end
            PENDING: begin
                // Request/enable changes are deliberately not looked at:
                // once taken, an interrupt always runs to completion.
                irq_next = 1'b1;
                if (int_rst_i) begin
                    state_next = FINISH;
                    irq_next   = 1'b0;
                    fin_next   = line_sel;
                end
            end
            FINISH: begin
                // Resume after the serviced line so a held line can't starve others.
                state_next = SCAN;
                irq_next   = 1'b0;
                idx_next   = idx_inc;
            end
            default: begin
                state_next = SCAN;
                irq_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg  <= SCAN;
            idx_reg    <= '0;
            irq_reg    <= 1'b0;
            mcause_reg <= '0;
            fin_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            irq_reg    <= irq_next;
            mcause_reg <= mcause_next;
            fin_reg    <= fin_next;
        end
    end

    assign irq_o     = irq_reg;
    assign mcause_o  = mcause_reg;
    assign int_fin_o = fin_reg;

endmodule : irq_ctrl

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl -- self-checking bench for irq_ctrl with scoreboard queues
// for expected mcause values and expected int_fin pulses.
module tb_irq_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] mie_i;
    logic [31:0] int_req_i;
    logic [31:0] int_fin_o;
    logic        int_rst_i;
    logic        irq_o;
    logic [31:0] mcause_o;

    int total;
    int bad;

    logic [31:0] exp_cause_q[$];
    logic [31:0] exp_fin_q[$];

    irq_ctrl #(
        .N_IRQ      (32),
        .CAUSE_BASE (16)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .mie_i     (mie_i),
        .int_req_i (int_req_i),
        .int_fin_o (int_fin_o),
        .int_rst_i (int_rst_i),
        .irq_o     (irq_o),
        .mcause_o  (mcause_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_reset(input logic [31:0] req, input logic [31:0] mie);
        rst_i     = 1'b0;
        int_rst_i = 1'b0;
        int_req_i = req;
        mie_i     = mie;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    // Counts falling edges until irq_o is high, bounded by max_cycles.
    task automatic wait_irq(input int max_cycles, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk_i);
            cycles++;
            if (irq_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_i     = 1'b0;
        int_rst_i = 1'b0;
        int_req_i = 32'hFFFF_FFFF;
        mie_i     = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk_i);
        total++;
        if (irq_o !== 1'b0 || int_fin_o !== 32'h0 || mcause_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: got irq=%b fin=%h mcause=%h want irq=0 fin=0 mcause=0",
                     irq_o, int_fin_o, mcause_o);
        end
        $display("txn reset: irq=%b fin=%h mcause=%h", irq_o, int_fin_o, mcause_o);
    endtask

    task automatic test_single;
        int          cyc;
        bit          ok;
        logic [31:0] exp;
        do_reset(32'h1, 32'h1);
        exp_cause_q.push_back(32'h8000_0010);
        wait_irq(4, cyc, ok);
        exp = exp_cause_q.pop_front();
        total++;
        if (!ok || cyc != 1) begin
            bad++;
            $display("FAIL single_latency: got ok=%0d cycles=%0d want cycles=1", ok, cyc);
        end
        total++;
        if (mcause_o !== exp) begin
            bad++;
            $display("FAIL single_mcause: got %h want %h", mcause_o, exp);
        end
        int_rst_i = 1'b1;
        exp_fin_q.push_back(32'h1);
        @(negedge clk_i);
        int_rst_i = 1'b0;
        exp = exp_fin_q.pop_front();
        total++;
        if (int_fin_o !== exp || irq_o !== 1'b0) begin
            bad++;
            $display("FAIL single_fin: got fin=%h irq=%b want fin=%h irq=0", int_fin_o, irq_o, exp);
        end
        @(negedge clk_i);
        total++;
        if (int_fin_o !== 32'h0) begin
            bad++;
            $display("FAIL single_fin_width: got fin=%h want 00000000", int_fin_o);
        end
        $display("txn single: mcause=%h fin=%h", exp, 32'h1);
    endtask

    task automatic test_latency;
        int          cyc;
        bit          ok;
        logic [31:0] exp;
        do_reset(32'h8000_0000, 32'hFFFF_FFFF);
        exp_cause_q.push_back(32'h8000_002F);
        wait_irq(40, cyc, ok);
        exp = exp_cause_q.pop_front();
        total++;
        if (!ok || cyc != 32) begin
            bad++;
            $display("FAIL worst_latency: got ok=%0d cycles=%0d want cycles=32", ok, cyc);
        end
        total++;
        if (mcause_o !== exp) begin
            bad++;
            $display("FAIL worst_mcause: got %h want %h", mcause_o, exp);
        end
        $display("txn latency: cycles=%0d mcause=%h", cyc, mcause_o);
    endtask

    task automatic test_fairness;
        int          cyc;
        bit          ok;
        logic [31:0] exp;
        logic [31:0] fin_exp;
        do_reset(32'h5, 32'h5);
        exp_cause_q.push_back(32'h8000_0010);
        exp_cause_q.push_back(32'h8000_0012);
        exp_cause_q.push_back(32'h8000_0010);
        for (int n = 0; n < 3; n++) begin
            wait_irq(40, cyc, ok);
            exp = exp_cause_q.pop_front();
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL fair_timeout: round %0d got no irq within 40 cycles", n);
            end
            total++;
            if (mcause_o !== exp) begin
                bad++;
                $display("FAIL fair_mcause: round %0d got %h want %h", n, mcause_o, exp);
            end
            int_rst_i = 1'b1;
            exp_fin_q.push_back(32'h1 << (exp[30:0] - 31'd16));
            @(negedge clk_i);
            int_rst_i = 1'b0;
            fin_exp = exp_fin_q.pop_front();
            total++;
            if (int_fin_o !== fin_exp) begin
                bad++;
                $display("FAIL fair_fin: round %0d got %h want %h", n, int_fin_o, fin_exp);
            end
            $display("txn fair %0d: mcause=%h fin=%h", n, mcause_o, int_fin_o);
        end
    endtask

    task automatic test_masked;
        int          cyc;
        bit          ok;
        int          leaks;
        logic [31:0] exp;
        do_reset(32'h4, 32'h0);
        leaks = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (irq_o !== 1'b0 || int_fin_o !== 32'h0) leaks++;
        end
        total++;
        if (leaks != 0) begin
            bad++;
            $display("FAIL masked_quiet: got %0d active cycles want 0", leaks);
        end
        mie_i = 32'h4;
        exp_cause_q.push_back(32'h8000_0012);
        wait_irq(33, cyc, ok);
        exp = exp_cause_q.pop_front();
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL masked_enable: got no irq within 33 cycles");
        end
        total++;
        if (mcause_o !== exp) begin
            bad++;
            $display("FAIL masked_mcause: got %h want %h", mcause_o, exp);
        end
        $display("txn masked: cycles=%0d mcause=%h", cyc, mcause_o);
    endtask

    task automatic test_withdraw;
        int          cyc;
        bit          ok;
        logic [31:0] exp;
        do_reset(32'h0, 32'h0);
        @(negedge clk_i);
        int_rst_i = 1'b1;  // strobe while scanning: must do nothing
        @(negedge clk_i);
        int_rst_i = 1'b0;
        total++;
        if (irq_o !== 1'b0 || int_fin_o !== 32'h0) begin
            bad++;
            $display("FAIL scan_strobe: got irq=%b fin=%h want irq=0 fin=0", irq_o, int_fin_o);
        end
        int_req_i = 32'h2;
        mie_i     = 32'h2;
        exp_cause_q.push_back(32'h8000_0011);
        wait_irq(40, cyc, ok);
        int_req_i = 32'h0;
        mie_i     = 32'h0;
        exp = exp_cause_q.pop_front();
        repeat (3) @(negedge clk_i);
        total++;
        if (!ok || irq_o !== 1'b1 || mcause_o !== exp) begin
            bad++;
            $display("FAIL withdraw_hold: got ok=%0d irq=%b mcause=%h want irq=1 mcause=%h",
                     ok, irq_o, mcause_o, exp);
        end
        int_rst_i = 1'b1;
        exp_fin_q.push_back(32'h2);
        @(negedge clk_i);
        int_rst_i = 1'b0;
        exp = exp_fin_q.pop_front();
        total++;
        if (int_fin_o !== exp || irq_o !== 1'b0) begin
            bad++;
            $display("FAIL withdraw_fin: got fin=%h irq=%b want fin=%h irq=0", int_fin_o, irq_o, exp);
        end
        @(negedge clk_i);
        total++;
        if (mcause_o !== 32'h8000_0011 || irq_o !== 1'b0) begin
            bad++;
            $display("FAIL mcause_keep: got mcause=%h irq=%b want 80000011 irq=0", mcause_o, irq_o);
        end
        $display("txn withdraw: fin=%h mcause=%h", exp, mcause_o);
    endtask

    task automatic test_reset_mid;
        int          cyc;
        bit          ok;
        logic [31:0] exp;
        do_reset(32'h8, 32'h8);
        wait_irq(40, cyc, ok);
        total++;
        if (!ok || mcause_o !== 32'h8000_0013) begin
            bad++;
            $display("FAIL mid_setup: got ok=%0d mcause=%h want 80000013", ok, mcause_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (irq_o !== 1'b0 || int_fin_o !== 32'h0 || mcause_o !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset: got irq=%b fin=%h mcause=%h want all 0",
                     irq_o, int_fin_o, mcause_o);
        end
        rst_i = 1'b1;
        exp_cause_q.push_back(32'h8000_0013);
        wait_irq(40, cyc, ok);
        exp = exp_cause_q.pop_front();
        total++;
        if (!ok || cyc != 4 || mcause_o !== exp) begin
            bad++;
            $display("FAIL mid_restart: got ok=%0d cycles=%0d mcause=%h want cycles=4 mcause=%h",
                     ok, cyc, mcause_o, exp);
        end
        $display("txn reset_mid: cycles=%0d mcause=%h", cyc, mcause_o);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_i     = 1'b0;
        int_rst_i = 1'b0;
        int_req_i = '0;
        mie_i     = '0;
        test_reset();
        test_single();
        test_latency();
        test_fairness();
        test_masked();
        test_withdraw();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_irq_ctrl

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- CPU-side end of the peripheral interrupt handshake (int_req/int_fin) used by the switch and other I/O controllers.
- Scans the masked request lines round-robin and raises a single interrupt to the core with an mcause value.
- When the core's handler returns (mret), pulses the matching int_fin line so the peripheral drops its request.
- Sits between the peripheral bus/interrupt lines and the core's CSR/trap logic.

Parameters:
- N_IRQ, 32, number of implemented request lines (1..32); bits at or above N_IRQ are ignored and their fin bits are driven 0.
- CAUSE_BASE, 16, cause code of line 0; line k reports CAUSE_BASE+k.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- mie_i  in  32  per-line interrupt enable, from the CSR mie register.
- int_req_i  in  32  level requests from peripherals; bit k belongs to line k.
- int_fin_o  out  32  one-hot, one-cycle completion pulse to peripherals.
- int_rst_i  in  1  core handler-return strobe (mret executed), one cycle.
- irq_o  out  1  interrupt request to the core; level signal.
- mcause_o  out  32  cause for the pending interrupt: bit31=1, bits[30:0]=CAUSE_BASE+idx.

Behaviour:
- Reset (rst_i==0 at a clock edge):
  - state=SCAN, idx=0.
  - irq_o=0, int_fin_o=0, mcause_o=0.
- hit = int_req_i[idx] & mie_i[idx] (and idx<N_IRQ).
- States:
  - SCAN, hit=0: idx <= idx+1, wrapping N_IRQ-1 -> 0.
  - SCAN, hit=1: idx is held; next state PENDING; irq_o and mcause_o are registered, so both are valid the cycle after the hit.
  - PENDING: irq_o=1; mcause_o is stable and holds idx.
    - int_rst_i==1 -> FINISH.
    - Changes on int_req_i or mie_i are ignored; an interrupt already taken always completes.
  - FINISH (exactly 1 cycle): irq_o=0, int_fin_o = 1<<idx; then SCAN with idx <= idx+1 (wrap). int_fin_o=0 in every other state.
- Latency:
  - Request on the current idx: irq_o rises 1 cycle after the request is seen.
  - Worst case: N_IRQ cycles of scan plus 1 cycle.
- Fairness: the round-robin continues after the serviced line, so a line that is held high cannot starve the others.
- int_rst_i in SCAN or FINISH: ignored, with no side effects.
- Request withdrawn during PENDING: the interrupt still completes and the int_fin pulse is still issued.
- Only one interrupt is ever outstanding; nesting is not supported.
- mcause_o keeps its last value after FINISH until the next hit overwrites it.
- Reset mid-operation: PENDING or FINISH aborts; irq_o drops and no int_fin pulse is issued.

Decomposition:
- Package irq_ctrl_pkg holds:
  - state enum {SCAN, PENDING, FINISH};
  - constant MCAUSE_INT_BIT = 31;
  - width IDX_W = 5.
- No sub-module. The scan counter, FSM and one-hot decode stay flat in one module.

Test Plan:
- Reset, then int_req_i=0x1, mie_i=0x1 -> irq_o=1 by cycle 2 with mcause_o=0x8000_0010; pulse int_rst_i -> next cycle int_fin_o=0x1 for exactly 1 cycle and irq_o=0.
- int_req_i=0x8000_0000, mie_i=0xFFFF_FFFF from reset -> irq_o rises exactly 32 cycles after reset release; mcause_o=0x8000_002F.
- int_req_i=0x5 held high, mie_i=0x5 -> line 0 is serviced first, then line 2, then line 0 again; mcause_o alternates 0x8000_0010 / 0x8000_0012.
- int_req_i=0x4, mie_i=0x0 for 100 cycles -> irq_o stays 0 and int_fin_o stays 0; set mie_i=0x4 -> irq_o within 33 cycles.
- In PENDING, drop int_req_i and clear mie_i, then pulse int_rst_i -> int_fin_o still pulses the original bit; int_rst_i pulsed in SCAN has no effect.
- Assert rst_i=0 while in PENDING -> next edge irq_o=0, int_fin_o=0, mcause_o=0; scanning restarts at idx 0.
